// File: rtl/lcd_img_proc_if.sv
// lcd_img_proc_if: command, IROM read and IRAM write signals of the LCD image processor.
// Ports: cmd/cmd_valid/busy/done (host), IROM_rd/IROM_A/IROM_Q (read), IRAM_valid/IRAM_A/IRAM_D (write).
// master = host/memory side, slave = lcd_img_proc side.
interface lcd_img_proc_if #(
  parameter int DW = 8,
  parameter int AW = 6
);
  logic [3:0]    cmd;
  logic          cmd_valid;
  logic          busy;
  logic          done;
  logic          IROM_rd;
  logic [AW-1:0] IROM_A;
  logic [DW-1:0] IROM_Q;
  logic          IRAM_valid;
  logic [AW-1:0] IRAM_A;
  logic [DW-1:0] IRAM_D;

  modport master (
    output cmd, cmd_valid, IROM_Q,
    input  busy, done, IROM_rd, IROM_A, IRAM_valid, IRAM_A, IRAM_D
  );

  modport slave (
    input  cmd, cmd_valid, IROM_Q,
    output busy, done, IROM_rd, IROM_A, IRAM_valid, IRAM_A, IRAM_D
  );
endinterface

// File: rtl/lcd_img_proc.sv
// lcd_img_proc: load IMG_W x IMG_H image from IROM, apply host commands to a 2x2 window, stream to IRAM.
// Latency: busy low N+2 cycles after reset release; each non-write cmd holds busy 1 cycle; write takes N+1 cycles.
// Backpressure: cmd_valid is only sampled while busy=0; strobes seen while busy are dropped, never queued.
// Ports: clk, reset (synchronous, active-low), bus (lcd_img_proc_if.slave).
// Option: define LCD_UNDO_EN to snapshot the last window-modifying op (cmds 5-11) and enable cmd 12 UNDO.
module lcd_img_proc #(
  parameter int DW     = 8,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int AW     = 6,
  parameter int ORIG_X = 3,
  parameter int ORIG_Y = 3
) (
  input  logic          clk,
  input  logic          reset,
  lcd_img_proc_if.slave bus
);
  localparam int N  = IMG_W * IMG_H;
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int CW = AW + 2;
  localparam int SW = DW + 2;

  typedef enum logic [2:0] {S_LOAD, S_WAIT, S_EXEC, S_OUT, S_DONE} state_t;
  state_t state, state_nxt;

  logic [CW-1:0] cnt;
  logic [AW-1:0] ld_addr;
  logic [XW-1:0] win_x;
  logic [YW-1:0] win_y;
  logic [3:0]    cmd_q;
  logic [DW-1:0] img [N];

  logic          rom_rd;
  logic [AW-1:0] rom_a;
  logic          ram_vld;
  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_d;

  logic [AW-1:0] pa [4];
  logic [DW-1:0] pv [4];
  logic [AW-1:0] wa [4];
  logic [DW-1:0] wd [4];
  logic          win_wr;
  logic [SW-1:0] sum;
  logic [DW-1:0] pmax, pmin;

`ifdef LCD_UNDO_EN
  logic          snap_vld;
  logic [XW-1:0] snap_x;
  logic [YW-1:0] snap_y;
  logic [DW-1:0] snap_px [4];
`endif

  // Quad index i: 0=(x,y) 1=(x+1,y) 2=(x,y+1) 3=(x+1,y+1); address is row-major {y,x}.
  function automatic logic [AW-1:0] quad_addr(input logic [YW-1:0] y, input logic [XW-1:0] x,
                                              input int i);
    logic [YW-1:0] yy;
    logic [XW-1:0] xx;
    yy = y + YW'(i / 2);
    xx = x + XW'(i % 2);
    return AW'({yy, xx});
  endfunction

  assign bus.busy       = (state != S_WAIT);
  assign bus.done       = (state == S_DONE);
  assign bus.IROM_rd    = rom_rd;
  assign bus.IROM_A     = rom_a;
  assign bus.IRAM_valid = ram_vld;
  assign bus.IRAM_A     = ram_a;
  assign bus.IRAM_D     = ram_d;

  // IROM_Q for the address issued at count c arrives while count is c+2.
  assign ld_addr = AW'(cnt - CW'(2));

  always_ff @(posedge clk) begin
    if (!reset) state <= S_LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD: if (cnt == CW'(N + 2)) state_nxt = S_WAIT;
      S_WAIT: if (bus.cmd_valid) state_nxt = (bus.cmd == 4'd0) ? S_OUT : S_EXEC;
      S_EXEC: state_nxt = S_WAIT;
      S_OUT:  if (cnt == CW'(N)) state_nxt = S_DONE;
      S_DONE: state_nxt = S_DONE;
      default: state_nxt = S_LOAD;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pa[i] = quad_addr(win_y, win_x, i);
      pv[i] = img[pa[i]];
    end
  end

  // Window op results; every write is computed from pre-op pixel values.
  always_comb begin
    sum    = '0;
    pmax   = pv[0];
    pmin   = pv[0];
    win_wr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wa[i] = pa[i];
      wd[i] = pv[i];
      sum   = sum + SW'(pv[i]);
      if (pv[i] > pmax) pmax = pv[i];
      if (pv[i] < pmin) pmin = pv[i];
    end
    if (state == S_EXEC) begin
      case (cmd_q)
        4'd5: begin win_wr = 1'b1; for (int i = 0; i < 4; i++) wd[i] = pmax; end
        4'd6: begin win_wr = 1'b1; for (int i = 0; i < 4; i++) wd[i] = pmin; end
        4'd7: begin win_wr = 1'b1; for (int i = 0; i < 4; i++) wd[i] = sum[SW-1:2]; end
        4'd8: begin win_wr = 1'b1; wd[0] = pv[1]; wd[1] = pv[3]; wd[3] = pv[2]; wd[2] = pv[0]; end
        4'd9: begin win_wr = 1'b1; wd[0] = pv[2]; wd[2] = pv[3]; wd[3] = pv[1]; wd[1] = pv[0]; end
        4'd10: begin win_wr = 1'b1; wd[0] = pv[2]; wd[1] = pv[3]; wd[2] = pv[0]; wd[3] = pv[1]; end
        4'd11: begin win_wr = 1'b1; wd[0] = pv[1]; wd[1] = pv[0]; wd[2] = pv[3]; wd[3] = pv[2]; end
`ifdef LCD_UNDO_EN
        4'd12: if (snap_vld) begin
          win_wr = 1'b1;
          for (int i = 0; i < 4; i++) begin
            wa[i] = quad_addr(snap_y, snap_x, i);
            wd[i] = snap_px[i];
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Image buffer has no reset; a fresh load overwrites every pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state == S_LOAD && cnt >= CW'(2) && cnt <= CW'(N + 1))
        img[ld_addr] <= bus.IROM_Q;
      else if (win_wr)
        for (int i = 0; i < 4; i++) img[wa[i]] <= wd[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt      <= '0;
      win_x    <= XW'(ORIG_X);
      win_y    <= YW'(ORIG_Y);
      cmd_q    <= '0;
      rom_rd   <= 1'b0;
      rom_a    <= '0;
      ram_vld  <= 1'b0;
      ram_a    <= '0;
      ram_d    <= '0;
`ifdef LCD_UNDO_EN
      snap_vld <= 1'b0;
`endif
    end else begin
      rom_rd  <= 1'b0;
      ram_vld <= 1'b0;
      case (state)
        S_LOAD: begin
          cnt <= cnt + CW'(1);
          if (cnt < CW'(N)) begin
            rom_rd <= 1'b1;
            rom_a  <= cnt[AW-1:0];
          end
        end
        S_WAIT: if (bus.cmd_valid) begin
          cmd_q <= bus.cmd;
          cnt   <= '0;
        end
        S_EXEC: begin
          case (cmd_q)
            4'd1: if (win_y != '0) win_y <= win_y - YW'(1);
            4'd2: if (win_y < YW'(IMG_H - 2)) win_y <= win_y + YW'(1);
            4'd3: if (win_x != '0) win_x <= win_x - XW'(1);
            4'd4: if (win_x < XW'(IMG_W - 2)) win_x <= win_x + XW'(1);
            default: ;
          endcase
`ifdef LCD_UNDO_EN
          if (cmd_q >= 4'd5 && cmd_q <= 4'd11) begin
            snap_vld <= 1'b1;
            snap_x   <= win_x;
            snap_y   <= win_y;
            for (int i = 0; i < 4; i++) snap_px[i] <= pv[i];
          end else if (cmd_q == 4'd12) begin
            snap_vld <= 1'b0;
          end
`endif
        end
        S_OUT: if (cnt < CW'(N)) begin
          ram_vld <= 1'b1;
          ram_a   <= cnt[AW-1:0];
          ram_d   <= img[cnt[AW-1:0]];
          cnt     <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_img_proc.sv
// tb_lcd_img_proc: randomized and directed bench for lcd_img_proc against an array-level reference model.
// Ports: none; instantiates lcd_img_proc_if and an IROM model with one-cycle read latency.
// Honours LCD_UNDO_EN in the model when the design is built with it.
module tb_lcd_img_proc;
  localparam int DW = 8;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int AW = 6;
  localparam int N  = W * H;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lcd_img_proc_if #(.DW(DW), .AW(AW)) bus ();

  lcd_img_proc #(.DW(DW), .IMG_W(W), .IMG_H(H), .AW(AW), .ORIG_X(3), .ORIG_Y(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DW-1:0] rom [N];
  always @(posedge clk) if (bus.IROM_rd) bus.IROM_Q <= rom[bus.IROM_A];

  int total = 0;
  int bad   = 0;

  int m_img [N];
  int got_img [N];
  int wx, wy;
  bit snap_v;
  int snap_px [4];
  int sx, sy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int quad(input int x, input int y, input int i);
    return (y + i / 2) * W + x + i % 2;
  endfunction

  task automatic model_load();
    for (int k = 0; k < N; k++) m_img[k] = int'(rom[k]);
    wx = 3; wy = 3; snap_v = 0;
  endtask

  task automatic model_apply(input int c);
    int o [4];
    int n [4];
    int mx, mn, s;
    for (int i = 0; i < 4; i++) o[i] = m_img[quad(wx, wy, i)];
    n = o;
    mx = o[0]; mn = o[0]; s = 0;
    for (int i = 0; i < 4; i++) begin
      if (o[i] > mx) mx = o[i];
      if (o[i] < mn) mn = o[i];
      s += o[i];
    end
    case (c)
      1: if (wy > 0) wy--;
      2: if (wy < H - 2) wy++;
      3: if (wx > 0) wx--;
      4: if (wx < W - 2) wx++;
      5: for (int i = 0; i < 4; i++) n[i] = mx;
      6: for (int i = 0; i < 4; i++) n[i] = mn;
      7: for (int i = 0; i < 4; i++) n[i] = s / 4;
      8: begin n[0] = o[1]; n[1] = o[3]; n[3] = o[2]; n[2] = o[0]; end
      9: begin n[0] = o[2]; n[2] = o[3]; n[3] = o[1]; n[1] = o[0]; end
      10: begin n[0] = o[2]; n[1] = o[3]; n[2] = o[0]; n[3] = o[1]; end
      11: begin n[0] = o[1]; n[1] = o[0]; n[2] = o[3]; n[3] = o[2]; end
`ifdef LCD_UNDO_EN
      12: if (snap_v) begin
        for (int i = 0; i < 4; i++) m_img[quad(sx, sy, i)] = snap_px[i];
        snap_v = 0;
      end
`endif
      default: ;
    endcase
    if (c >= 5 && c <= 11) begin
`ifdef LCD_UNDO_EN
      snap_v = 1; sx = wx; sy = wy; snap_px = o;
`endif
      for (int i = 0; i < 4; i++) m_img[quad(wx, wy, i)] = n[i];
    end
  endtask

  task automatic do_reset();
    int k;
    @(negedge clk);
    reset = 1'b0;
    bus.cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 1);
    check("rst_done", bus.done, 0);
    check("rst_irom_rd", bus.IROM_rd, 0);
    check("rst_irom_a", bus.IROM_A, 0);
    check("rst_iram_valid", bus.IRAM_valid, 0);
    check("rst_iram_a", bus.IRAM_A, 0);
    check("rst_iram_d", bus.IRAM_D, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("load_first_rd", bus.IROM_rd, 1);
    check("load_first_a", bus.IROM_A, 0);
    k = 0;
    while (bus.busy && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("load_cycles", k, N + 2);
    model_load();
  endtask

  // Accepts one command; a junk command stays strobed through the busy cycle and must be dropped.
  task automatic send_cmd(input int c);
    @(negedge clk);
    bus.cmd = 4'(c);
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    check("cmd_busy", bus.busy, 1);
    bus.cmd = 4'($urandom_range(1, 15));
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    check("cmd_release", bus.busy, 0);
    model_apply(c);
  endtask

  task automatic do_write(input string tag);
    int idx, cyc;
    idx = 0; cyc = 0;
    @(negedge clk);
    bus.cmd = 4'd0;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd = 4'd5;
    check("wr_busy", bus.busy, 1);
    check("wr_valid_early", bus.IRAM_valid, 0);
    while (!bus.done && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.IRAM_valid) begin
        if (idx == 0) check("wr_first_cycle", cyc, 1);
        check("wr_addr", bus.IRAM_A, idx % N);
        got_img[idx % N] = int'(bus.IRAM_D);
        check("wr_done_early", bus.done, 0);
        idx++;
      end
    end
    check("wr_count", idx, N);
    check("wr_done_cycle", cyc, N + 1);
    check("wr_done", bus.done, 1);
    check("wr_busy_end", bus.busy, 1);
    check("wr_valid_end", bus.IRAM_valid, 0);
    for (int i = 0; i < N; i++) check({tag, "_pixel"}, got_img[i], m_img[i]);
    repeat (3) @(posedge clk);
    #1;
    check("done_sticky", bus.done, 1);
    check("done_quiet", bus.IRAM_valid, 0);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic ramp_quad(input int a, input int b, input int c, input int d);
    for (int k = 0; k < N; k++) rom[k] = DW'(k);
    rom[27] = DW'(a); rom[28] = DW'(b); rom[35] = DW'(c); rom[36] = DW'(d);
  endtask

  task automatic check_quad(input string tag, input int a, input int b, input int c, input int d);
    check({tag, "_p0"}, got_img[27], a);
    check({tag, "_p1"}, got_img[28], b);
    check({tag, "_p2"}, got_img[35], c);
    check({tag, "_p3"}, got_img[36], d);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.cmd = 4'd0;
    bus.cmd_valid = 1'b0;

    // Plain ramp round trip.
    for (int k = 0; k < N; k++) rom[k] = DW'(k);
    do_reset();
    do_write("ramp");

    // AVG / MAX / MIN on 10,20,30,200.
    ramp_quad(10, 20, 30, 200); do_reset(); send_cmd(7); do_write("avg");
    check_quad("avg", 65, 65, 65, 65);
    ramp_quad(10, 20, 30, 200); do_reset(); send_cmd(5); do_write("max");
    check_quad("max", 200, 200, 200, 200);
    ramp_quad(10, 20, 30, 200); do_reset(); send_cmd(6); do_write("min");
    check_quad("min", 10, 10, 10, 10);

    // Clamping shifts: to (0,0), then RIGHT x8 stops at x=6.
    for (int k = 0; k < N; k++) rom[k] = DW'(k);
    do_reset();
    repeat (7) send_cmd(1);
    repeat (7) send_cmd(3);
    send_cmd(5);
    repeat (8) send_cmd(4);
    send_cmd(5);
    do_write("shift");
    check("shift_origin", got_img[9], 9);
    check("shift_origin0", got_img[0], 9);
    check("shift_right_edge", got_img[15], 15);
    check("shift_right_p0", got_img[6], 15);

    // Rotations and mirrors.
    ramp_quad(1, 2, 3, 4); do_reset(); send_cmd(9); do_write("cw");
    check_quad("cw", 3, 1, 4, 2);
    ramp_quad(1, 2, 3, 4); do_reset();
    send_cmd(9); send_cmd(8); send_cmd(10); send_cmd(11);
    do_write("rot");
    check_quad("rot", 4, 3, 2, 1);

    // Reset in the middle of OUT, then reload different content.
    ramp_quad(1, 2, 3, 4); do_reset(); send_cmd(5);
    @(negedge clk);
    bus.cmd = 4'd0;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid_out_valid", bus.IRAM_valid, 1);
    for (int k = 0; k < N; k++) rom[k] = DW'($urandom_range(0, 255));
    do_reset();
    do_write("reload");

    // Snapshot / UNDO, including a second UNDO.
    ramp_quad(1, 2, 3, 4); do_reset();
    send_cmd(5); send_cmd(4); send_cmd(12); send_cmd(12);
    do_write("undo");
`ifdef LCD_UNDO_EN
    check_quad("undo", 1, 2, 3, 4);
`else
    check_quad("undo", 4, 4, 4, 4);
`endif
    check("undo_neighbour", got_img[29], 29);

    // Random images and command streams.
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < N; k++) rom[k] = DW'($urandom_range(0, 255));
      do_reset();
      for (int j = 0; j < 25; j++) send_cmd($urandom_range(1, 15));
      do_write("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
